// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the sequential Booth multiplier.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_if.sv
// Request/result bundle between a requester (master) and the multiplier (slave).
interface mult_if #(parameter int WIDTH = mult_pkg::WIDTH);

  logic             control;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output control, A_in, B_in, input done, Hi, Lo);
  modport slave  (input control, A_in, B_in, output done, Hi, Lo);

endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into the upper
// half of P, then an arithmetic shift right by one.
module booth_step #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [2*WIDTH:0] i_p,
  input  logic [WIDTH-1:0] i_m,
  output logic [2*WIDTH:0] o_pNext
);

  logic [WIDTH:0] w_hiExt;
  logic [WIDTH:0] w_mExt;
  logic [WIDTH:0] w_sum;

  // The sum is formed one bit wider so the bit shifted into P[64] is the true
  // sign even when M = -2^31 would overflow a 32-bit add/subtract.
  assign w_hiExt = {i_p[2*WIDTH], i_p[2*WIDTH:WIDTH+1]};
  assign w_mExt  = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = w_hiExt;
    case (i_p[1:0])
      2'b01:   w_sum = w_hiExt + w_mExt;
      2'b10:   w_sum = w_hiExt - w_mExt;
      default: w_sum = w_hiExt;
    endcase
  end

  assign o_pNext = {w_sum, i_p[WIDTH:1]};

endmodule

// File: rtl/mult.sv
// Sequential 32x32 signed Booth multiplier: one load edge plus ITER run edges,
// result held in DONE until the requester drops control.
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int ITER  = mult_pkg::ITER
) (
  input  logic  clk,
  input  logic  reset,
  mult_if.slave bus
);

  localparam logic [5:0] LAST_COUNT = 6'(ITER - 1);

  state_t             r_state;
  state_t             w_stateNext;
  logic [5:0]         r_count;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH:0]   r_p;
  logic [2*WIDTH:0]   w_pNext;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               w_lastIter;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_p     (r_p),
    .i_m     (r_m),
    .o_pNext (w_pNext)
  );

  assign w_lastIter = (r_count == LAST_COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.control) w_stateNext = RUN;
      RUN: begin
        if (!bus.control)    w_stateNext = IDLE;
        else if (w_lastIter) w_stateNext = DONE;
      end
      DONE:    if (!bus.control) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Hi/Lo are only written on the completion edge, so an abort or reset
  // never exposes a partial product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.control) begin
            r_m     <= bus.A_in;
            r_p     <= {{WIDTH{1'b0}}, bus.B_in, 1'b0};
            r_count <= '0;
          end
        end
        RUN: begin
          if (bus.control) begin
            r_p     <= w_pNext;
            r_count <= r_count + 6'd1;
            if (w_lastIter) begin
              r_hi   <= w_pNext[2*WIDTH:WIDTH+1];
              r_lo   <= w_pNext[WIDTH:1];
              r_done <= 1'b1;
            end
          end else begin
            r_done <= 1'b0;
          end
        end
        DONE: if (!bus.control) r_done <= 1'b0;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.done = r_done;
  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: drivers push expected products, a monitor pops
// and compares on each rising edge of done.
module tb_mult;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  logic [63:0] expQ[$];
  logic prevDone;

  mult_if #(.WIDTH(32)) bus ();

  mult #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: every fresh done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset) begin
      prevDone <= 1'b0;
    end else begin
      if (bus.done === 1'b1 && prevDone !== 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", {32'h0, 31'h0, bus.done}, 64'h0);
        end else begin
          logic [63:0] exp;
          exp = expQ.pop_front();
          checkOutput("product", {bus.Hi, bus.Lo}, exp);
        end
      end
      prevDone <= bus.done;
    end
  end

  // Full operation: load, optional operand scrambling during RUN, latency,
  // hold in DONE, then release back to IDLE.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected, input bit scramble);
    int edges;
    @(negedge clk);
    bus.A_in = a;
    bus.B_in = b;
    bus.control = 1'b1;
    expQ.push_back(expected);
    edges = 0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      if (scramble) begin
        bus.A_in = $urandom;
        bus.B_in = $urandom;
      end
      if (bus.done === 1'b1) break;
    end
    checkOutput("latency", 64'(edges), 64'd33);
    repeat (2) @(negedge clk);
    checkOutput("hold_done", {63'h0, bus.done}, 64'h1);
    checkOutput("hold_result", {bus.Hi, bus.Lo}, expected);
    bus.control = 1'b0;
    @(negedge clk);
    checkOutput("release_done", {63'h0, bus.done}, 64'h0);
    checkOutput("release_result", {bus.Hi, bus.Lo}, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount = 0;
    bus.control = 1'b0;
    bus.A_in = '0;
    bus.B_in = '0;
    reset = 1'b1;
    #12;
    checkOutput("reset_done", {63'h0, bus.done}, 64'h0);
    checkOutput("reset_result", {bus.Hi, bus.Lo}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b0);

    // Abort 3*3 partway through RUN: previous result must survive.
    @(negedge clk);
    bus.A_in = 32'd3;
    bus.B_in = 32'd3;
    bus.control = 1'b1;
    repeat (10) @(negedge clk);
    bus.control = 1'b0;
    @(negedge clk);
    checkOutput("abort_done", {63'h0, bus.done}, 64'h0);
    checkOutput("abort_result", {bus.Hi, bus.Lo}, 64'h0000_0000_0000_002A);
    repeat (30) @(negedge clk);
    checkOutput("abort_idle_done", {63'h0, bus.done}, 64'h0);

    applyStimulus(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0);
    applyStimulus(32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b1);

    // Asynchronous reset in the middle of a 7*6 run.
    @(negedge clk);
    bus.A_in = 32'd7;
    bus.B_in = 32'd6;
    bus.control = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_done", {63'h0, bus.done}, 64'h0);
    checkOutput("async_reset_result", {bus.Hi, bus.Lo}, 64'h0);
    bus.control = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(32'd2, 32'd2, 64'h0000_0000_0000_0004, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
